// File: rtl/pipelined_csel_addsub.sv
// pipelined_csel_addsub: segmented carry-select adder/subtractor
// one segment resolved per stage, valid/ready on both sides
module pipelined_csel_addsub #(
    parameter int WIDTH = 32,
    parameter int SEGS  = 4,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int SEG  = WIDTH / SEGS;
    localparam int NBLK = SEG / BLK;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;
    assign b_eff    = b ^ {WIDTH{sub}};
    assign cin_eff  = c_in ^ sub;

    for (genvar k = 0; k < SEGS; k++) begin : g_stg
        localparam int LO = (k + 1) * SEG;
        localparam int HI = WIDTH - LO;

        logic           v_d;
        logic           ci_d;
        logic           co_d;
        logic           v_q;
        logic           c_q;
        logic [SEG-1:0] sa_d;
        logic [SEG-1:0] sb_d;
        logic [SEG-1:0] s_d;
        logic [LO-1:0]  lo_d;
        logic [LO-1:0]  lo_q;
        logic [NBLK:0]  cc;

        if (k == 0) begin : g_src
            assign v_d  = in_valid;
            assign ci_d = cin_eff;
            assign sa_d = a[SEG-1:0];
            assign sb_d = b_eff[SEG-1:0];
            assign lo_d = s_d;
        end else begin : g_src
            assign v_d  = g_stg[k-1].v_q;
            assign ci_d = g_stg[k-1].c_q;
            assign sa_d = g_stg[k-1].g_hi.ahi_q[SEG-1:0];
            assign sb_d = g_stg[k-1].g_hi.bhi_q[SEG-1:0];
            assign lo_d = {s_d, g_stg[k-1].lo_q};
        end

        assign cc[0] = ci_d;

        for (genvar j = 0; j < NBLK; j++) begin : g_blk
            logic [BLK:0] r0;
            logic [BLK:0] r1;

            assign r0 = {1'b0, sa_d[j*BLK +: BLK]}
                      + {1'b0, sb_d[j*BLK +: BLK]};
            assign r1 = {1'b0, sa_d[j*BLK +: BLK]}
                      + {1'b0, sb_d[j*BLK +: BLK]}
                      + {{BLK{1'b0}}, 1'b1};
            assign s_d[j*BLK +: BLK] = cc[j] ? r1[BLK-1:0] : r0[BLK-1:0];
            assign cc[j+1]           = cc[j] ? r1[BLK] : r0[BLK];
        end

        assign co_d = cc[NBLK];

        // stage valid, resolved low sum and segment carry advance together
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q  <= 1'b0;
                c_q  <= 1'b0;
                lo_q <= '0;
            end else if (adv) begin
                v_q  <= v_d;
                c_q  <= co_d;
                lo_q <= lo_d;
            end
        end

        if (HI > 0) begin : g_hi
            logic [HI-1:0] ahi_d;
            logic [HI-1:0] bhi_d;
            logic [HI-1:0] ahi_q;
            logic [HI-1:0] bhi_q;

            if (k == 0) begin : g_ld
                assign ahi_d = a[WIDTH-1:LO];
                assign bhi_d = b_eff[WIDTH-1:LO];
            end else begin : g_ld
                assign ahi_d = g_stg[k-1].g_hi.ahi_q[HI+SEG-1:SEG];
                assign bhi_d = g_stg[k-1].g_hi.bhi_q[HI+SEG-1:SEG];
            end

            // skew the still-unresolved operand bits down the pipe
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ahi_q <= '0;
                    bhi_q <= '0;
                end else if (adv) begin
                    ahi_q <= ahi_d;
                    bhi_q <= bhi_d;
                end
            end
        end else begin : g_out
            logic ovf_q;
            logic zero_q;

            // flags from the top segment: carry-in to MSB recovered from sum bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= co_d ^ sa_d[SEG-1] ^ sb_d[SEG-1] ^ s_d[SEG-1];
                    zero_q <= ~|lo_d;
                end
            end
        end
    end

    assign out_valid = g_stg[SEGS-1].v_q;
    assign sum       = g_stg[SEGS-1].lo_q;
    assign c_out     = g_stg[SEGS-1].c_q;
    assign ovf       = g_stg[SEGS-1].g_out.ovf_q;
    assign zero      = g_stg[SEGS-1].g_out.zero_q;

endmodule

// File: tb/tb_pipelined_csel_addsub.sv
// tb_pipelined_csel_addsub: random and directed checks against
// an arithmetic reference model, plus a parameter sweep
module tb_pipelined_csel_addsub;

    typedef struct packed {
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    typedef struct {
        int   t;
        res_t r;
    } ent_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sb;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    localparam int S0 = 4;
    localparam int NV = 10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sw_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
    logic        zero;

    int   n_chk = 0;
    int   n_err = 0;
    int   sw_done = 0;
    int   got_n;
    logic mv [S0];
    res_t mres [S0];
    vec_t dv [6];

    always #5 clk = ~clk;

    pipelined_csel_addsub #(.WIDTH(32), .SEGS(S0), .BLK(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic res_t ref_op(input int w, input logic [63:0] x,
                                    input logic [63:0] y, input logic ci,
                                    input logic sb);
        logic [64:0] mask;
        logic [64:0] full;
        logic [63:0] xm;
        logic [63:0] ym;
        res_t        r;
        mask = (65'd1 << w) - 65'd1;
        xm   = x & mask[63:0];
        ym   = (sb ? ~y : y) & mask[63:0];
        full = {1'b0, xm} + {1'b0, ym} + {64'd0, (sb ? ~ci : ci)};
        r.s  = full[63:0] & mask[63:0];
        r.co = full[w];
        r.ov = (xm[w-1] == ym[w-1]) && (r.s[w-1] != xm[w-1]);
        r.z  = (r.s == 64'd0);
        return r;
    endfunction

    function automatic logic busy();
        logic v;
        v = 1'b0;
        for (int i = 0; i < S0; i++) v |= mv[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < S0; i++) begin
            mv[i]   = 1'b0;
            mres[i] = '0;
        end
    endtask

    task automatic cycle(output logic acc);
        logic adv;
        res_t r;
        #1;
        adv = !(mv[S0-1] && !out_ready);
        chk("in_ready", in_ready, adv);
        acc = in_valid && adv;
        if (mv[S0-1] && out_ready) got_n++;
        r = ref_op(32, {32'd0, a}, {32'd0, b}, c_in, sub);
        @(posedge clk);
        if (adv) begin
            for (int i = S0 - 1; i > 0; i--) begin
                mv[i]   = mv[i-1];
                mres[i] = mres[i-1];
            end
            mv[0]   = in_valid;
            mres[0] = r;
        end
        #1;
        chk("out_valid", out_valid, mv[S0-1]);
        if (mv[S0-1]) begin
            chk("sum", sum, mres[S0-1].s);
            chk("c_out", c_out, mres[S0-1].co);
            chk("ovf", ovf, mres[S0-1].ov);
            chk("zero", zero, mres[S0-1].z);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : 64;
        localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : 8;
        localparam int K = (g == 0) ? 4 : (g == 1) ? 2 : 4;

        logic         iv;
        logic         ir;
        logic         ovl;
        logic         ci;
        logic         sb;
        logic         co;
        logic         of;
        logic         zr;
        logic         ordy;
        logic [W-1:0] xa;
        logic [W-1:0] xb;
        logic [W-1:0] xs;
        ent_t         q[$];
        ent_t         e;
        int           cyc;
        int           nv;
        logic         ev;

        pipelined_csel_addsub #(.WIDTH(W), .SEGS(S), .BLK(K)) u_dut (
            .clk(clk), .rst_n(sw_rst_n),
            .in_valid(iv), .in_ready(ir),
            .a(xa), .b(xb), .c_in(ci), .sub(sb),
            .out_valid(ovl), .out_ready(ordy),
            .sum(xs), .c_out(co), .ovf(of), .zero(zr)
        );

        initial begin
            iv = 1'b0; xa = '0; xb = '0; ci = 1'b0; sb = 1'b0; ordy = 1'b1;
            cyc = 0; nv = 0;
            wait (sw_rst_n === 1'b1);
            while ((nv < NV || q.size() > 0) && cyc < 20000) begin
                @(posedge clk);
                cyc++;
                if (iv) begin
                    e.t = cyc;
                    e.r = ref_op(W, 64'(xa), 64'(xb), ci, sb);
                    q.push_back(e);
                end
                #1;
                chk($sformatf("sw%0d_ready", g), ir, 1'b1);
                ev = q.size() > 0 && (q[0].t + S - 1 == cyc);
                chk($sformatf("sw%0d_valid", g), ovl, ev);
                if (ev) begin
                    e = q.pop_front();
                    chk($sformatf("sw%0d_sum", g), 64'(xs), e.r.s);
                    chk($sformatf("sw%0d_cout", g), co, e.r.co);
                    chk($sformatf("sw%0d_ovf", g), of, e.r.ov);
                    chk($sformatf("sw%0d_zero", g), zr, e.r.z);
                end
                iv = (nv < NV) && ($urandom_range(3) != 0);
                if (iv) begin
                    xa = W'({$urandom, $urandom});
                    xb = W'({$urandom, $urandom});
                    ci = 1'($urandom_range(1));
                    sb = 1'($urandom_range(1));
                    nv++;
                end
            end
            chk($sformatf("sw%0d_drain", g), q.size(), 0);
            sw_done++;
        end
    end

    initial begin
        logic acc;
        logic need;
        int   lat;
        int   t;
        int   issued;

        dv[0] = '{32'd9, 32'd5, 1'b0, 1'b0, 32'd14, 1'b0, 1'b0, 1'b0};
        dv[1] = '{32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1};
        dv[2] = '{32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        dv[3] = '{32'd14, 32'd13, 1'b0, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0};
        dv[4] = '{32'd0, 32'd1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        dv[5] = '{32'd900, 32'd90, 1'b1, 1'b1, 32'd809, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; sw_rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        got_n = 0;
        model_clear();
        #2;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_cout", c_out, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_zero", zero, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; sw_rst_n = 1'b1;

        for (int d = 0; d < 6; d++) begin
            a = dv[d].a; b = dv[d].b; c_in = dv[d].ci; sub = dv[d].sb;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 12) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("d%0d_lat", d), lat, S0);
            chk($sformatf("d%0d_sum", d), sum, dv[d].s);
            chk($sformatf("d%0d_cout", d), c_out, dv[d].co);
            chk($sformatf("d%0d_ovf", d), ovf, dv[d].ov);
            chk($sformatf("d%0d_zero", d), zero, dv[d].z);
            @(posedge clk);
            #1;
            chk($sformatf("d%0d_gone", d), out_valid, 1'b0);
        end

        model_clear();
        got_n = 0; issued = 0; t = 0; need = 1'b1;
        while ((issued < 20 || busy()) && t < 200) begin
            if (need) begin
                a = $urandom; b = $urandom;
                c_in = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
                need = 1'b0;
            end
            in_valid  = (issued < 20) && !(t == 9 || t == 10);
            out_ready = !(t == 6 || t == 7 || t == 8 || t == 13);
            cycle(acc);
            if (acc) begin
                issued++;
                need = 1'b1;
            end
            t++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_bound", t < 200, 1'b1);
        chk("stream_count", got_n, 20);

        issued = 0;
        while (issued < 5) begin
            a = $urandom | 32'd1; b = '0; c_in = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            cycle(acc);
            if (acc) issued++;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_sum", sum, 32'd0);
        chk("mrst_cout", c_out, 1'b0);
        chk("mrst_ovf", ovf, 1'b0);
        chk("mrst_zero", zero, 1'b0);
        chk("mrst_ready", in_ready, 1'b1);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) cycle(acc);
        a = 32'h1234_5678; b = 32'h0000_1111; c_in = 1'b1; sub = 1'b1;
        in_valid = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        repeat (6) cycle(acc);

        for (int i = 0; i < 25000 && sw_done < 3; i++) @(posedge clk);
        chk("sweep_done", sw_done, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
